// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
// Operand width default matches the companion sequential divider.
package mult_pkg;

  localparam int C_NUM_BITS_DFLT = 24;
  localparam int C_CNT_BITS      = $clog2(C_NUM_BITS_DFLT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Step counter width for a non-default operand width; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2 partial-product step: conditional add of the multiplicand into
// the carry-extended accumulator, then a logical right shift of {acc, mlr}.
module mult_step
  import mult_pkg::*;
#(
  parameter int C_NUM_BITS = C_NUM_BITS_DFLT
) (
  input  logic [C_NUM_BITS:0]   acc,
  input  logic [C_NUM_BITS-1:0] mlr,
  input  logic [C_NUM_BITS-1:0] mcd,
  output logic [C_NUM_BITS:0]   acc_nxt,
  output logic [C_NUM_BITS-1:0] mlr_nxt
);

  logic [C_NUM_BITS:0] addend;
  logic [C_NUM_BITS:0] sum;

  always_comb begin
    addend = mlr[0] ? {1'b0, mcd} : '0;
    // acc never exceeds C_NUM_BITS significant bits after a shift, so the
    // extra carry bit is enough to hold the sum without loss.
    sum    = acc + addend;
    {acc_nxt, mlr_nxt} = {1'b0, sum, mlr[C_NUM_BITS-1:1]};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial-product step per
// enabled cycle, 2*C_NUM_BITS-bit product with a one-cycle DONE strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for START; P holds the last completed product
// RUN   | one shift-add step per enabled edge, C_NUM_BITS steps total
// FIN   | P newly valid, DONE high until the next enabled edge
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int C_NUM_BITS = C_NUM_BITS_DFLT
) (
  input  logic                      CK,
  input  logic                      R,
  input  logic                      E,
  input  logic                      START,
  input  logic [C_NUM_BITS-1:0]     A,
  input  logic [C_NUM_BITS-1:0]     B,
  output logic [2*C_NUM_BITS-1:0]   P,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int CW = (C_NUM_BITS == C_NUM_BITS_DFLT) ? C_CNT_BITS
                                                      : cnt_width(C_NUM_BITS);

  state_t                state;
  state_t                state_nxt;
  logic [C_NUM_BITS:0]   acc;
  logic [C_NUM_BITS-1:0] mlr;
  logic [C_NUM_BITS-1:0] mcd;
  logic [CW-1:0]         cnt;
  logic [C_NUM_BITS:0]   acc_nxt;
  logic [C_NUM_BITS-1:0] mlr_nxt;
  logic                  last_step;

  assign last_step = (cnt == CW'(C_NUM_BITS - 1));

  mult_step #(
    .C_NUM_BITS (C_NUM_BITS)
  ) u_step (
    .acc     (acc),
    .mlr     (mlr),
    .mcd     (mcd),
    .acc_nxt (acc_nxt),
    .mlr_nxt (mlr_nxt)
  );

  always_ff @(posedge CK) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (E) begin
      case (state)
        IDLE:    if (START) state_nxt = RUN;
        RUN:     if (last_step) state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY = (state != IDLE);
    DONE = (state == FIN);
  end

  // Datapath registers; everything freezes while E is low.
  always_ff @(posedge CK) begin
    if (R) begin
      acc <= '0;
      mlr <= '0;
      mcd <= '0;
      cnt <= '0;
      P   <= '0;
    end else if (E) begin
      case (state)
        IDLE: begin
          if (START) begin
            acc <= '0;
            mlr <= B;
            mcd <= A;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          mlr <= mlr_nxt;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            P <= {acc_nxt[C_NUM_BITS-1:0], mlr_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed vector table, abort/reset
// sequences and randomized back-to-back products against plain arithmetic.
module tb_shift_add_multiplier;

  localparam int N = 24;

  logic           CK = 1'b0;
  logic           R;
  logic           E;
  logic           START;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           BUSY;
  logic           DONE;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp_p;
    int             mode;   // 0 plain, 1 START pulse mid-run, 2 E toggling
  } vec_t;

  vec_t vecs[8];

  shift_add_multiplier #(
    .C_NUM_BITS (N)
  ) dut (
    .CK    (CK),
    .R     (R),
    .E     (E),
    .START (START),
    .A     (A),
    .B     (B),
    .P     (P),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CK = ~CK;

  function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned x;
    x = longint'(a) * longint'(b);
    return x[2*N-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int  en_edges;
    int  extra;
    bit  seen;
    A = v.a; B = v.b; START = 1'b1; E = 1'b1;
    step();
    START = 1'b0; A = N'($urandom); B = N'($urandom);
    chk($sformatf("v%0d busy_after_accept", idx), 64'(BUSY), 64'd1);
    en_edges = 0;
    seen     = 1'b0;
    for (int m = 1; m < 200 && !seen; m++) begin
      E = (v.mode == 2) ? m[0] : 1'b1;
      if (v.mode == 1 && m == 5) begin
        START = 1'b1; A = N'(7); B = N'(9);
      end else begin
        START = 1'b0;
      end
      @(posedge CK);
      if (E) en_edges++;
      @(negedge CK);
      if (DONE) seen = 1'b1;
    end
    START = 1'b0;
    if (!seen) begin
      chk($sformatf("v%0d done_timeout", idx), 64'd0, 64'd1);
    end else begin
      chk($sformatf("v%0d latency_enabled_edges", idx), 64'(en_edges), 64'(N));
      chk($sformatf("v%0d product", idx), 64'(P), 64'(v.exp_p));
      if (v.mode == 2) begin
        E = 1'b0;
        step();
        step();
        chk($sformatf("v%0d done_hold_stalled", idx), 64'(DONE), 64'd1);
        chk($sformatf("v%0d p_hold_stalled", idx), 64'(P), 64'(v.exp_p));
      end
      E = 1'b1;
      step();
      chk($sformatf("v%0d done_one_cycle", idx), 64'(DONE), 64'd0);
      chk($sformatf("v%0d busy_fall", idx), 64'(BUSY), 64'd0);
      if (v.mode == 1) begin
        extra = 0;
        for (int i = 0; i < 30; i++) begin
          step();
          if (DONE) extra++;
        end
        chk($sformatf("v%0d no_extra_done", idx), 64'(extra), 64'd0);
      end
    end
  endtask

  initial begin
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic [2*N-1:0] q[$];
    logic [2*N-1:0] e;
    int             cyc;
    int             last;
    int             got;
    int             extra;

    vecs[0] = '{24'h000003, 24'h000005, 48'h00000000000F, 0};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0};
    vecs[2] = '{24'h000000, 24'h123456, 48'h000000000000, 0};
    vecs[3] = '{24'h000123, 24'h000456, 48'h00000004EDC2, 1};
    vecs[4] = '{24'h000007, 24'h000009, 48'h00000000003F, 0};
    vecs[5] = '{24'h000100, 24'h000200, 48'h000000020000, 2};
    vecs[6] = '{24'h800000, 24'h000002, 48'h000001000000, 0};
    vecs[7] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 0};

    R = 1'b1; E = 1'b0; START = 1'b0; A = '0; B = '0;
    step();
    step();
    chk("reset_p", 64'(P), 64'd0);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    R = 1'b0; E = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_op(vecs[i], i);

    // Abort at step 10: reset clears P and no DONE follows.
    A = 24'h00ABCD; B = 24'h001234; START = 1'b1; E = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 10; i++) step();
    R = 1'b1;
    step();
    chk("abort_p", 64'(P), 64'd0);
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    R = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (DONE || BUSY) extra++;
    end
    chk("abort_no_activity", 64'(extra), 64'd0);

    // Reset and START together: START is dropped.
    R = 1'b1; START = 1'b1;
    step();
    chk("r_start_busy", 64'(BUSY), 64'd0);
    R = 1'b0; START = 1'b0;
    step();
    chk("r_start_stays_idle", 64'(BUSY), 64'd0);

    // Random back-to-back with START held high.
    ra = N'($urandom); rb = N'($urandom);
    q.push_back(prod(ra, rb));
    A = ra; B = rb; START = 1'b1; E = 1'b1;
    cyc = 0; last = -1; got = 0;
    while (got < 1000 && cyc < 1000 * 26 + 200) begin
      step();
      cyc++;
      if (DONE) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_p_%0d", got), 64'(P), 64'(e));
        end
        if (last >= 0) chk($sformatf("rand_spacing_%0d", got), 64'(cyc - last), 64'd26);
        last = cyc;
        got++;
        if (got < 1000) begin
          ra = N'($urandom); rb = N'($urandom);
          q.push_back(prod(ra, rb));
          A = ra; B = rb;
        end else begin
          START = 1'b0;
        end
      end
    end
    if (got < 1000) chk("rand_timeout_results", 64'(got), 64'd1000);
    step();
    step();
    chk("rand_final_idle", 64'(BUSY), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
